uart_tx: RTL and testbench

//   Synthesizable 8N1 UART transmitter driving top-level uart_txd; the

---
 rtl/uart_tx.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter. Bytes arrive over a valid/ready port
//               into a small FIFO and are serialized LSB first on uart_txd
//               at BAUD_DIV clocks per bit. Back-to-back frames leave no
//               idle gap.
// Ports       : clk        - system clock, rising edge
//               rst_n      - asynchronous active-low reset
//               tx_data    - byte to send
//               tx_valid   - tx_data valid
//               tx_ready   - FIFO can accept (not full)
//               fifo_count - bytes queued, excluding the byte in the shifter
//               busy       - FSM not idle or FIFO non-empty
//               uart_txd   - registered serial output, idle high
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_tx #(
    parameter int BAUD_DIV   = 139,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          uart_txd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] C_BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    // Pointers carry one extra wrap bit so full and empty are distinct.
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic [7:0]  fifo_head;

    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_head  = fifo_mem[rd_ptr_q[AW-1:0]];

    assign tx_ready   = ~fifo_full;
    assign push       = tx_valid & ~fifo_full;
    assign fifo_count = wr_ptr_q - rd_ptr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= tx_data;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [BW-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic            baud_wrap;

    assign baud_wrap = (baud_cnt_q == C_BAUD_LAST);

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    state_d = S_START;
                end
            end

            S_START: begin
                baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + BW'(1);
                if (baud_wrap) begin
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end

            S_DATA: begin
                baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + BW'(1);
                if (baud_wrap) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end

            S_STOP: begin
                baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + BW'(1);
                if (baud_wrap) begin
                    // Chain straight into the next start bit when data waits.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The line level follows the current state, so it changes on the edge
    // after a state is entered and each level is held BAUD_DIV clocks.
    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    assign uart_txd = txd_q;
    assign busy     = (state_q != S_IDLE) || !fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx (BAUD_DIV=4, FIFO_DEPTH=4).
//               A line decoder captures each 40-clock frame, checks framing
//               and compares the byte against the accepted-byte queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx;

    localparam int BAUD_DIV   = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME      = 10 * BAUD_DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [2:0] fifo_count;
    logic       busy;
    logic       uart_txd;

    uart_tx #(
        .BAUD_DIV   (BAUD_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .fifo_count (fifo_count),
        .busy       (busy),
        .uart_txd   (uart_txd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Bytes accepted by the DUT and not yet seen on the line, in order.
    logic [7:0] exp_q[$];
    // Cycle index of the first low sample of each decoded start bit.
    int         start_q[$];

    // ------------------------------------------------------------------
    // Line decoder: one sample per clock, 40 samples per frame.
    // ------------------------------------------------------------------
    int          rx_n = -1;
    logic [39:0] rx_bits;

    task automatic decode_frame();
        logic       ok;
        logic [7:0] b;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            for (int j = 1; j < BAUD_DIV; j++) begin
                if (rx_bits[i*BAUD_DIV+j] !== rx_bits[i*BAUD_DIV]) ok = 1'b0;
            end
        end
        if (rx_bits[9*BAUD_DIV] !== 1'b1) ok = 1'b0;
        for (int i = 0; i < 8; i++) b[i] = rx_bits[(i+1)*BAUD_DIV];
        check_eq("frame_ok", ok, 1);
        check_eq("rx_byte_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            check_eq("rx_byte", b, exp_q.pop_front());
        end
    endtask

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_n = -1;
        end else if (rx_n < 0) begin
            if (uart_txd == 1'b0) begin
                rx_bits[0] = 1'b0;
                rx_n = 1;
                start_q.push_back(cyc);
            end
        end else begin
            rx_bits[rx_n] = uart_txd;
            rx_n++;
            if (rx_n == FRAME) begin
                decode_frame();
                rx_n = -1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge, return at a falling edge)
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b, output int acc);
        logic rdy;
        acc = -1;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int t = 0; t < 2000 && acc < 0; t++) begin
            rdy = tx_ready;
            @(posedge clk);
            @(negedge clk);
            if (rdy) begin
                acc = cyc;
                exp_q.push_back(b);
            end
        end
        tx_valid = 1'b0;
        check_eq("send_timeout", acc >= 0, 1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || rx_n >= 0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check_eq("idle_timeout", t < 5000, 1);
        repeat (3) @(negedge clk);
        check_eq("idle_txd", uart_txd, 1);
        check_eq("idle_count", fifo_count, 0);
        check_eq("idle_ready", tx_ready, 1);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int k, k2, k6;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Quiet after reset.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check_eq("rst_txd", uart_txd, 1);
            check_eq("rst_ready", tx_ready, 1);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_count", fifo_count, 0);
        end

        // Single byte: latency and busy timing.
        start_q.delete();
        send_byte(8'h55, k);
        while (cyc < k + 40) @(negedge clk);
        check_eq("t2_busy_last", busy, 1);
        @(negedge clk);
        check_eq("t2_busy_fall", busy, 0);
        wait_idle();
        check_eq("t2_frames", start_q.size(), 1);
        if (start_q.size() > 0) check_eq("t2_latency", start_q[0] - k, 2);

        // Two bytes on consecutive clocks: contiguous frames.
        start_q.delete();
        send_byte(8'hA5, k);
        send_byte(8'h3C, k2);
        check_eq("t3_consecutive", k2 - k, 1);
        wait_idle();
        check_eq("t3_frames", start_q.size(), 2);
        if (start_q.size() == 2) check_eq("t3_gap", start_q[1] - start_q[0], FRAME);

        // Back-pressure: fill the FIFO behind the shifter.
        send_byte(8'h01, k);
        for (int b = 2; b <= 5; b++) send_byte(8'(b), k2);
        check_eq("t4_count_full", fifo_count, FIFO_DEPTH);
        check_eq("t4_ready_full", tx_ready, 0);
        check_eq("t4_busy", busy, 1);
        send_byte(8'h06, k6);
        check_eq("t4_accept6", k6 - k, 42);
        wait_idle();
        check_eq("t4_drained", exp_q.size(), 0);

        // Reset during data bit 3 of 0xF0.
        send_byte(8'hF0, k);
        send_byte(8'h12, k2);
        while (cyc < k + 19) @(negedge clk);
        check_eq("t5_bit3", uart_txd, 0);
        check_eq("t5_count", fifo_count, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_txd", uart_txd, 1);
        check_eq("t5_rst_count", fifo_count, 0);
        check_eq("t5_rst_busy", busy, 0);
        check_eq("t5_rst_ready", tx_ready, 1);
        exp_q.delete();
        tx_data  = 8'hEE;
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("t5_post_busy", busy, 0);
        check_eq("t5_post_count", fifo_count, 0);
        check_eq("t5_post_txd", uart_txd, 1);
        start_q.delete();
        send_byte(8'h81, k);
        wait_idle();
        check_eq("t5_frames", start_q.size(), 1);

        // Extremes of the data pattern.
        send_byte(8'h00, k);
        send_byte(8'hFF, k);
        wait_idle();

        // Random bytes with random gaps, including bursts that fill the FIFO.
        for (int i = 0; i < 30; i++) begin
            int gap;
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 0;
            repeat (gap) @(negedge clk);
            send_byte(8'($urandom), k);
        end
        wait_idle();
        check_eq("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
